// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding and address/tag field positions for the dcache controller.
package dcache_pkg;

    localparam int SET_W      = 4;
    localparam int TAG_W      = 23;
    localparam int LINE_W     = 256;
    localparam int WORD_W     = 32;
    localparam int WSEL_W     = 3;
    localparam int TAG_LSB    = 9;
    localparam int IDX_LSB    = 5;
    localparam int WORD_LSB   = 2;
    localparam int VALID_BIT  = 24;
    localparam int DIRTY_BIT  = 23;
    localparam int LADDR_W    = 32 - IDX_LSB;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        REFILL,
        REFILL_DONE
    } state_e;

endpackage

// File: rtl/dcache_word_merge.sv
// dcache_word_merge: selects one 32-bit word of a cache line and builds the line with that word replaced.
module dcache_word_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0] line_i,
    input  logic [WSEL_W-1:0] sel_i,
    input  logic [WORD_W-1:0] word_i,
    output logic [WORD_W-1:0] word_o,
    output logic [LINE_W-1:0] line_o
);

    assign word_o = line_i[{sel_i, 5'b0} +: WORD_W];

    always_comb begin
        line_o = line_i;
        line_o[{sel_i, 5'b0} +: WORD_W] = word_i;
    end

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: write-back, write-allocate control for a 2-way dcache with zero-latency hits.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cpu_req_i,
    input  logic               cpu_write_i,
    input  logic [31:0]        cpu_addr_i,
    input  logic [WORD_W-1:0]  cpu_data_i,
    output logic [WORD_W-1:0]  cpu_data_o,
    output logic               cpu_stall_o,
    output logic               sram_enable_o,
    output logic               sram_write_o,
    output logic [SET_W-1:0]   sram_addr_o,
    output logic [TAG_W+1:0]   sram_tag_o,
    output logic [LINE_W-1:0]  sram_data_o,
    input  logic [TAG_W+1:0]   sram_tag_i,
    input  logic [LINE_W-1:0]  sram_data_i,
    input  logic               sram_hit_i,
    output logic               mem_enable_o,
    output logic               mem_write_o,
    output logic [31:0]        mem_addr_o,
    output logic [LINE_W-1:0]  mem_data_o,
    input  logic [LINE_W-1:0]  mem_data_i,
    input  logic               mem_ack_i
);

    state_e               state_q, state_d;
    logic [TAG_W+1:0]     vtag_q, vtag_d;
    logic [LINE_W-1:0]    vdata_q, vdata_d;
    logic [LADDR_W-1:0]   laddr_q, laddr_d;
    logic [WORD_W-1:0]    rd_word;
    logic [LINE_W-1:0]    st_line;
    logic                 unused_addr;

    assign unused_addr   = ^cpu_addr_i[WORD_LSB-1:0];
    assign sram_addr_o   = cpu_addr_i[IDX_LSB +: SET_W];
    assign sram_enable_o = cpu_req_i;

    dcache_word_merge u_merge (
        .line_i (sram_data_i),
        .sel_i  (cpu_addr_i[WORD_LSB +: WSEL_W]),
        .word_i (cpu_data_i),
        .word_o (rd_word),
        .line_o (st_line)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            vtag_q  <= '0;
            vdata_q <= '0;
            laddr_q <= '0;
        end else begin
            state_q <= state_d;
            vtag_q  <= vtag_d;
            vdata_q <= vdata_d;
            laddr_q <= laddr_d;
        end
    end

    // The miss line address is latched so the memory side stays stable for the whole miss.
    always_comb begin
        state_d      = state_q;
        vtag_d       = vtag_q;
        vdata_d      = vdata_q;
        laddr_d      = laddr_q;
        cpu_data_o   = '0;
        cpu_stall_o  = cpu_req_i;
        sram_write_o = 1'b0;
        sram_tag_o   = '0;
        sram_data_o  = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state_q)
            IDLE: begin
                cpu_stall_o = cpu_req_i && !sram_hit_i;
                if (cpu_req_i && sram_hit_i) begin
                    cpu_data_o   = cpu_write_i ? '0 : rd_word;
                    sram_write_o = cpu_write_i;
                    sram_tag_o   = cpu_write_i ? {2'b11, cpu_addr_i[TAG_LSB +: TAG_W]} : '0;
                    sram_data_o  = cpu_write_i ? st_line : '0;
                end else if (cpu_req_i) begin
                    vtag_d  = sram_tag_i;
                    vdata_d = sram_data_i;
                    laddr_d = cpu_addr_i[31:IDX_LSB];
                    state_d = MISS;
                end
            end
            MISS: state_d = (vtag_q[VALID_BIT] && vtag_q[DIRTY_BIT]) ? WRITEBACK : REFILL;
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {vtag_q[TAG_W-1:0], laddr_q[SET_W-1:0], 5'b0};
                mem_data_o   = vdata_q;
                state_d      = mem_ack_i ? REFILL : WRITEBACK;
            end
            REFILL: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {laddr_q, 5'b0};
                sram_write_o = mem_ack_i;
                sram_data_o  = mem_ack_i ? mem_data_i : '0;
                sram_tag_o   = mem_ack_i ? {2'b10, laddr_q[LADDR_W-1:SET_W]} : '0;
                state_d      = mem_ack_i ? REFILL_DONE : REFILL;
            end
            REFILL_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Control stage directly upstream of the 2-way dcache SRAM (16 sets, 25-bit tag field, 256-bit lines).
- Accepts 32-bit word load/store requests from the CPU MEM stage and performs the tag lookup through the SRAM.
- On a miss, stalls the CPU, writes back a dirty victim line, refills the line from data memory, then replays the access.
- Write-back, write-allocate policy.

Parameters:
- SET_W, 4, index bits (16 sets)
- TAG_W, 23, address tag bits; SRAM tag field = {valid, dirty, tag} = TAG_W+2
- LINE_W, 256, line width in bits (32 bytes, 8 words)
- WORD_W, 32, CPU word width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- cpu_req_i  in  1  CPU access valid
- cpu_write_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address: tag [31:9], index [8:5], word [4:2]
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  CPU must hold request
- sram_enable_o  out  1  SRAM access
- sram_write_o  out  1  SRAM write
- sram_addr_o  out  4  set index
- sram_tag_o  out  25  {valid, dirty, tag}
- sram_data_o  out  256  line to write
- sram_tag_i  in  25  hit way tag, or LRU victim tag on miss
- sram_data_i  in  256  hit way line, or LRU victim line on miss
- sram_hit_i  in  1  valid tag match
- mem_enable_o  out  1  memory request, level, held until ack
- mem_write_o  out  1  1 = write-back, 0 = refill read
- mem_addr_o  out  32  line-aligned address, bits [4:0] = 0
- mem_data_o  out  256  write-back line
- mem_data_i  in  256  refill line
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- States: IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE.
- Reset (synchronous, rst_i=1 at clk edge) forces IDLE.
  - All outputs are 0 during and after reset until a request.
  - A memory transaction in flight is abandoned; mem_enable_o drops on the next cycle.
- sram_addr_o is always cpu_addr_i[8:5].
- sram_enable_o = cpu_req_i in all states.
- IDLE with cpu_req_i and sram_hit_i: zero-latency hit.
  - Load: cpu_data_o = sram_data_i word cpu_addr_i[4:2] (combinational); cpu_stall_o=0.
  - Store: sram_write_o=1, sram_data_o = sram_data_i with word [4:2] replaced by cpu_data_i, sram_tag_o = {1,1,tag}; cpu_stall_o=0. Write commits at the next edge.
- IDLE with cpu_req_i and !sram_hit_i: cpu_stall_o=1 combinationally; latch victim tag/data; go to MISS.
- MISS (1 cycle): victim valid&dirty (sram_tag_i[24] & [23]) -> go to WRITEBACK; otherwise -> go to REFILL.
- WRITEBACK:
  - mem_enable_o=1, mem_write_o=1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = latched victim line.
  - On mem_ack_i -> REFILL.
- REFILL:
  - mem_enable_o=1, mem_write_o=0, mem_addr_o = {cpu tag, index, 5'b0}.
  - On mem_ack_i: sram_write_o=1, sram_data_o = mem_data_i, sram_tag_o = {1,0,tag} -> REFILL_DONE.
- REFILL_DONE (1 cycle, stall held) -> IDLE; the request replays as a hit. A store then sets dirty.
- cpu_stall_o=1 in every non-IDLE state while cpu_req_i=1.
- mem_ack_i outside WRITEBACK/REFILL is ignored.
- An ack arriving in the first cycle of mem_enable_o is accepted.
- A clean miss has a minimum of 4 stall cycles when memory acks immediately.
- cpu_req_i dropping mid-miss does not abort the refill; the FSM completes to IDLE.
- The same set is never written twice in one cycle.

Decomposition:
- Shared package dcache_pkg holds:
  - state enum
  - field constants (TAG_LSB=9, IDX_LSB=5, WORD_LSB=2)
  - tag-field bit positions (VALID_BIT=24, DIRTY_BIT=23)
- One sub-module, dcache_word_merge: combinational word select and word insert on a 256-bit line.

Test Plan:
- Reset then load 0x0000_0040 with SRAM miss, clean victim, ack after 3 cycles:
  - mem read at 0x40; SRAM write tag {1,0,0}.
  - Replay returns word 0; stall high for exactly 6 cycles.
- Store 0xDEADBEEF to 0x44 after refill: hit, no stall, SRAM write tag {1,1,0}, word 1 = 0xDEADBEEF.
- Miss on 0x0000_0240 (same set 2) with dirty victim tag 0:
  - mem write to 0x40 with victim line first.
  - Then mem read at 0x240.
  - Order is checked.
- rst_i asserted during REFILL with mem_enable_o=1:
  - next cycle all outputs 0, state IDLE.
  - A late mem_ack_i is ignored.
- mem_ack_i asserted in the same cycle mem_enable_o first rises: the transaction is accepted, no hang.
- Spurious mem_ack_i in IDLE: no state change, no SRAM write.
